cycle_sequencer: RTL
====================

# cycle_sequencer

Machine-cycle sequencer and instruction fetcher for the TB4004 core. It steps the eight 4004 sub-cycles A1..X3 and drives the `cycle` bus consumed by the decoder. It emits the ROM address nibbles, latches the OPR/OPA nibbles plus the second word of two-word instructions, and owns the 12-bit program counter. It sits between the ROM and the instruction decoder and is the only source of `cycle`, `opr` and `opa`.

## Interface
- `PC_WIDTH`, 12, program counter width; fixed at 12 for 4004 compatibility.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rstN`  in  1  reset: synchronous, active-low.
- `runEn`  in  1  advance enable; low freezes all state (single-step / halt).
- `romData`  in  4  ROM nibble; valid in M1 and M2.
- `pcLoad`  in  1  jump request; sampled only at X3.
- `pcLoadAddr`  in  12  jump target.
- `cycle`  out  3  current sub-cycle: 0=A1, 1=A2, 2=A3, 3=M1, 4=M2, 5=X1, 6=X2, 7=X3.
- `sync`  out  1  high while `cycle`==7.
- `romAddr`  out  4  `pc[3:0]` in A1, `pc[7:4]` in A2, `pc[11:8]` in A3; 0 otherwise.
- `opr`  out  4  first-word opcode nibble.
- `opa`  out  4  first-word operand nibble.
- `secondWord`  out  1  high for all eight cycles of the second word of a two-word instruction.
- `operand2`  out  8  second instruction word.
- `instrDone`  out  1  high during X3 of an instruction's final word.
- `pc`  out  12  program counter.

## Operation
- **Reset** (`rstN`=0 at an edge): `cycle`=0, `pc`=0, `opr`=`opa`=0 (NOP), `operand2`=0, `secondWord`=0. Reset overrides `runEn` and `pcLoad`.
- **Frozen state:** with `runEn`=0, every register holds. Combinational outputs (`sync`, `romAddr`, `instrDone`) keep reflecting the held state.
- **Cycle counter:** with `runEn`=1, `cycle` advances 0→1→…→7→0. There is no skipping.
- **First word** (`secondWord`=0):
  - edge in M1: `opr`←`romData`
  - edge in M2: `opa`←`romData`
- **Second word** (`secondWord`=1):
  - edge in M1: `operand2[7:4]`←`romData`
  - edge in M2: `operand2[3:0]`←`romData`
  - `opr`/`opa` hold the first-word values throughout.
- **Two-word set:**
  - `opr`=0x1 (JCN)
  - `opr`=0x2 with `opa[0]`=0 (FIM)
  - `opr`=0x4 (JUN)
  - `opr`=0x5 (JMS)
  - `opr`=0x7 (ISZ)
  - Everything else is single-word, including SRC, FIN and JIN.
- **`secondWord` update at the X3 edge:**
  - set when currently 0 and the latched `opr`/`opa` are in the two-word set
  - cleared when currently 1
- **`instrDone`** = (`cycle`==7) & (`secondWord` | not two-word).
- **PC update at the X3 edge:**
  - if `pcLoad`=1: `pc`←`pcLoadAddr`
  - else: `pc`←`pc`+1 modulo 4096 (0xFFF→0x000)
  - A load applies to whichever word is ending. The decoder only raises it on the final word.
- `pcLoad` at any cycle other than X3 is ignored.

## Timing
- Each word takes exactly 8 enabled clocks; an instruction takes 8 or 16.
- `opr` is valid from M2 onward, and `opa` from X1 onward, of the first word. The decoder's X-cycle actions therefore see stable nibbles.
- `operand2` is complete from X1 of the second word.
- `pc` changes on the same edge that `cycle` goes 7→0, so A1 of the next word already addresses the new `pc`.
- **Simultaneous events at X3:**
  - `pcLoad` has priority over increment.
  - The `secondWord` toggle and the `pc` update happen on the same edge.
- **Reset mid-instruction**, including mid-second-word: the next cycle is A1 of a fresh first-word fetch at `pc`=0. Stale `operand2` is cleared.
- **`runEn` dropped in M1:** no nibble is latched until the edge on which `runEn`=1 with `cycle` still 3.

## Structure
- **Shared package `tb4004Pkg`:**
  - cycle constants `CYC_A1`..`CYC_X3`
  - the 4-bit opcode constants already used by the decoder (NOP..F_)
  - function `isTwoWord(opr, opa)`
  - The decoder and this block both import it.
- **Sub-module `program_counter`:** 12-bit register with synchronous active-low reset, increment and load inputs, enabled at X3.
- The cycle counter, nibble latches and `secondWord` flag live in the top module.

## Test plan
- **Reset and free run:** hold `rstN`=0 for 3 clocks, then release with `runEn`=1 → `cycle` reads 0,1,…,7,0; `romAddr`=0,0,0 in A1..A3; `sync` is high only while `cycle`==7; `pc`=1 after the first X3.
- **Single-word:** ROM returns 0xD then 0x5 at `pc`=0 → `opr`=0xD, `opa`=0x5, `secondWord` stays 0, `instrDone` is high in X3, `pc`=1.
- **Two-word JUN:** words 0x42 then 0x34, with `pcLoad`=1 and `pcLoadAddr`=0x234 in the second X3 → `secondWord`=1 for cycles 8–15, `operand2`=0x34, `instrDone` is low in the first X3 and high in the second, `pc`=0x234 and `romAddr`=0x4,0x3,0x2 in the next A1..A3.
- **Stall:** drop `runEn` for 5 clocks during M1 while `romData` changes → `cycle` holds at 3 and `opr` latches only the value present when `runEn` returns.
- **PC wrap:** load 0xFFF, then run a single-word NOP → `pc`=0x000 after X3. Also assert `pcLoad` in X1 → it is ignored.
- **Reset mid-second-word:** assert `rstN`=0 during X1 of the FIM (0x20) second word → `secondWord`=0, `operand2`=0, `pc`=0, `cycle`=0 on the next edge.

Source files
------------

// File: rtl/cycle_sequencer_pkg.sv
// Shared TB4004 definitions: sub-cycle encoding, opcode nibbles and the two-word decode.
// Imported by both the cycle sequencer and the instruction decoder.
package tb4004Pkg;

    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cycleT;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JCN = 4'h1;
    localparam logic [3:0] OP_FIM = 4'h2;  // FIM when opa[0]=0, SRC when opa[0]=1
    localparam logic [3:0] OP_FIN = 4'h3;  // FIN when opa[0]=0, JIN when opa[0]=1
    localparam logic [3:0] OP_JUN = 4'h4;
    localparam logic [3:0] OP_JMS = 4'h5;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_ISZ = 4'h7;
    localparam logic [3:0] OP_ADD = 4'h8;
    localparam logic [3:0] OP_SUB = 4'h9;
    localparam logic [3:0] OP_LD  = 4'hA;
    localparam logic [3:0] OP_XCH = 4'hB;
    localparam logic [3:0] OP_BBL = 4'hC;
    localparam logic [3:0] OP_LDM = 4'hD;
    localparam logic [3:0] OP_E_  = 4'hE;
    localparam logic [3:0] OP_F_  = 4'hF;

    function automatic logic isTwoWord(input logic [3:0] opr, input logic [3:0] opa);
        case (opr)
            OP_JCN, OP_JUN, OP_JMS, OP_ISZ: isTwoWord = 1'b1;
            OP_FIM:                         isTwoWord = ((opa & 4'h1) == 4'h0);
            default:                        isTwoWord = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/cycle_sequencer_pc.sv
// 12-bit program counter: load has priority over increment, both gated by en.
module program_counter #(
    parameter int PC_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                en,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] loadAddr,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rstN) begin
            pc <= '0;
        end else if (en) begin
            if (load) pc <= loadAddr;
            else      pc <= pc + PC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/cycle_sequencer.sv
// TB4004 machine-cycle sequencer: steps A1..X3, drives ROM address nibbles,
// latches OPR/OPA and the second instruction word, and owns the program counter.
module cycle_sequencer
    import tb4004Pkg::*;
#(
    parameter int PC_WIDTH = 12
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                runEn,
    input  logic [3:0]          romData,
    input  logic                pcLoad,
    input  logic [PC_WIDTH-1:0] pcLoadAddr,
    output logic [2:0]          cycle,
    output logic                sync,
    output logic [3:0]          romAddr,
    output logic [3:0]          opr,
    output logic [3:0]          opa,
    output logic                secondWord,
    output logic [7:0]          operand2,
    output logic                instrDone,
    output logic [PC_WIDTH-1:0] pc
);

    cycleT cycleQ;
    logic  atX3;
    logic  pcEn;

    assign atX3 = (cycleQ == CYC_X3);
    assign pcEn = runEn && atX3;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            cycleQ     <= CYC_A1;
            opr        <= OP_NOP;
            opa        <= 4'h0;
            operand2   <= 8'h00;
            secondWord <= 1'b0;
        end else if (runEn) begin
            cycleQ <= cycleT'(3'(cycleQ + 3'd1));
            if (cycleQ == CYC_M1) begin
                if (secondWord) operand2[7:4] <= romData;
                else            opr           <= romData;
            end
            if (cycleQ == CYC_M2) begin
                if (secondWord) operand2[3:0] <= romData;
                else            opa           <= romData;
            end
            if (atX3) begin
                if (secondWord)               secondWord <= 1'b0;
                else if (isTwoWord(opr, opa)) secondWord <= 1'b1;
            end
        end
    end

    program_counter #(.PC_WIDTH(PC_WIDTH)) uPc (
        .clk      (clk),
        .rstN     (rstN),
        .en       (pcEn),
        .load     (pcLoad),
        .loadAddr (pcLoadAddr),
        .pc       (pc)
    );

    always_comb begin
        romAddr = 4'h0;
        case (cycleQ)
            CYC_A1:  romAddr = pc[3:0];
            CYC_A2:  romAddr = pc[7:4];
            CYC_A3:  romAddr = pc[11:8];
            default: romAddr = 4'h0;
        endcase
    end

    assign cycle     = cycleQ;
    assign sync      = atX3;
    // Stale opr/opa during A1..M1 don't matter: instrDone is only meaningful at X3.
    assign instrDone = atX3 && (secondWord || !isTwoWord(opr, opa));

endmodule
